// File: rtl/pmod_ssd_driver.sv
// pmod_ssd_driver
//   Drives a two-digit multiplexed PmodSSD from an 8-bit value shown as two
//   hex digits. One select line time-multiplexes the digits; every digit slot
//   starts with a short blanked window so the previous digit's segments are
//   not seen on the newly selected digit (ghosting). The displayed byte is
//   taken from a shadow register that only reloads at the end of a full
//   frame (right slot then left slot), so one frame never mixes two values.
//
// Parameters
//   CLK_HZ        input clock frequency
//   REFRESH_HZ    digit-switch rate; DIV = CLK_HZ/REFRESH_HZ clocks per slot
//   BLANK_CYCLES  clocks at the start of every slot with segments off
//   LZ_BLANK      1 = blank the left digit when the high nibble is zero
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   value       byte to display; [7:4] left digit, [3:0] right digit
//   blank       1 = force all segments off (timing keeps running)
//   seg         segments {g,f,e,d,c,b,a}, active high, registered
//   sel         digit select: 0 = right digit, 1 = left digit, registered
//   frame_tick  one-clock pulse in the clock after the shadow register loads
module pmod_ssd_driver #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1_000,
  parameter int BLANK_CYCLES = 1_000,
  parameter int LZ_BLANK     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       sel,
  output logic       frame_tick
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  // Guard the width so a bad DIV reaches the elaboration check below
  // instead of failing on a zero-width vector first.
  localparam int DIV_W = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  // Elaboration-time sanity checks on the timing parameters.
  if (DIV < 2) begin : g_bad_div
    $error("pmod_ssd_driver: CLK_HZ/REFRESH_HZ must be at least 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= DIV) begin : g_bad_blank
    $error("pmod_ssd_driver: BLANK_CYCLES must satisfy 0 <= BLANK_CYCLES < DIV");
  end

  // ------------------------------------------------------------------------
  // Slot timing and shadow register
  // ------------------------------------------------------------------------
  logic [DIV_W-1:0] div_reg;     // position inside the current slot
  logic             slot_reg;    // 0 = right slot, 1 = left slot
  logic [7:0]       shadow_reg;  // value shown for the whole current frame
  logic             slot_end;

  assign slot_end = (div_reg == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg    <= '0;
      slot_reg   <= 1'b0;
      shadow_reg <= 8'h00;
      frame_tick <= 1'b0;
    end else begin
      if (slot_end) begin
        div_reg  <= '0;
        slot_reg <= ~slot_reg;
      end else begin
        div_reg  <= div_reg + 1'b1;
      end
      // A frame ends when the left slot ends; only then may the displayed
      // byte change.
      if (slot_end && slot_reg) begin
        shadow_reg <= value;
        frame_tick <= 1'b1;
      end else begin
        frame_tick <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Anti-ghosting window at the start of each slot
  // ------------------------------------------------------------------------
  logic in_blank_window;

  if (BLANK_CYCLES == 0) begin : g_no_window
    assign in_blank_window = 1'b0;
  end else begin : g_window
    localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYCLES);
    assign in_blank_window = (div_reg < BLANK_LIM);
  end

  // ------------------------------------------------------------------------
  // Hex to seven-segment decode
  // ------------------------------------------------------------------------
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // ------------------------------------------------------------------------
  // Output stage: sel and seg are registered on the same edge so the pins
  // never show a digit's segments under the other digit's select.
  // ------------------------------------------------------------------------
  logic [3:0] nibble;
  logic       lz_off;
  logic [6:0] seg_next;

  assign nibble = slot_reg ? shadow_reg[7:4] : shadow_reg[3:0];
  // Only the left digit is ever suppressed, so 0x00 still shows one "0".
  assign lz_off = (LZ_BLANK != 0) && slot_reg && (shadow_reg[7:4] == 4'h0);

  always_comb begin
    seg_next = hex7(nibble);
    if (blank || in_blank_window || lz_off) begin
      seg_next = 7'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= 7'h00;
      sel <= 1'b0;
    end else begin
      seg <= seg_next;
      sel <= slot_reg;
    end
  end

endmodule

// File: tb/tb_pmod_ssd_driver.sv
module tb_pmod_ssd_driver;

  localparam int DIV   = 10;
  localparam int BC    = 2;
  localparam int FRAME = 2 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = 8'h5A;
  logic       blank = 1'b0;

  logic [6:0] seg0, seg1;
  logic       sel0, sel1, ft0, ft1;

  always #5 clk = ~clk;

  // Instance without leading-zero blanking
  pmod_ssd_driver #(.CLK_HZ(100), .REFRESH_HZ(10), .BLANK_CYCLES(BC), .LZ_BLANK(0)) dut0 (
    .clk(clk), .rst(rst), .value(value), .blank(blank),
    .seg(seg0), .sel(sel0), .frame_tick(ft0)
  );

  // Instance with leading-zero blanking, same stimulus
  pmod_ssd_driver #(.CLK_HZ(100), .REFRESH_HZ(10), .BLANK_CYCLES(BC), .LZ_BLANK(1)) dut1 (
    .clk(clk), .rst(rst), .value(value), .blank(blank),
    .seg(seg1), .sel(sel1), .frame_tick(ft1)
  );

  typedef struct packed {
    logic [6:0] seg0;
    logic [6:0] seg1;
    logic       sel;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state: clocks since reset release and the byte the
  // current frame displays.
  int         m_n = 0;
  logic [7:0] m_shadow = 8'h00;

  // Apply inputs just after the previous edge, then advance one clock and
  // push what the display must show after that edge.
  task automatic step(input logic r, input logic [7:0] v, input logic b);
    exp_t e;
    int   pos, slot, off;
    logic [3:0] dig;
    #1;
    rst = r; value = v; blank = b;
    @(posedge clk);
    if (r) begin
      e = '0;
      m_n = 0;
      m_shadow = 8'h00;
    end else begin
      pos  = m_n % FRAME;
      slot = pos / DIV;          // 0 = right half of frame, 1 = left half
      off  = pos % DIV;
      dig  = (slot == 1) ? m_shadow[7:4] : m_shadow[3:0];
      e.sel  = (slot == 1);
      e.ft   = (pos == FRAME - 1);
      e.seg0 = (b || off < BC) ? 7'h00 : hex_tab[dig];
      e.seg1 = (b || off < BC || (slot == 1 && m_shadow[7:4] == 4'h0)) ? 7'h00 : hex_tab[dig];
      if (pos == FRAME - 1) m_shadow = v;
      m_n++;
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: every clock presents one display state; compare it against the
  // oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("seg_lz0", int'(seg0), int'(e.seg0));
        chk("seg_lz1", int'(seg1), int'(e.seg1));
        chk("sel_lz0", int'(sel0), int'(e.sel));
        chk("sel_lz1", int'(sel1), int'(e.sel));
        chk("frame_tick_lz0", int'(ft0), int'(e.ft));
        chk("frame_tick_lz1", int'(ft1), int'(e.ft));
        if (e.ft) $display("frame load at %0t: new shadow visible next frame", $time);
      end
    end
  end

  initial begin
    logic [7:0] v;
    logic       b;
    logic       r;
    int         guard;

    // Reset held for three clocks with a nonzero value present
    repeat (3) step(1'b1, 8'h5A, 1'b0);
    // First frame shows shadow 0, loads 0xA5 at its end
    repeat (35) step(1'b0, 8'hA5, 1'b0);
    // Change in the middle of a left slot; must wait for the next load
    repeat (30) step(1'b0, 8'h3C, 1'b0);
    // Leading-zero cases
    repeat (45) step(1'b0, 8'h07, 1'b0);
    repeat (45) step(1'b0, 8'h00, 1'b0);
    repeat (45) step(1'b0, 8'h10, 1'b0);
    // Blank for 15 clocks mid-slot, then resume
    repeat (3)  step(1'b0, 8'hE9, 1'b0);
    repeat (15) step(1'b0, 8'hE9, 1'b1);
    repeat (30) step(1'b0, 8'hE9, 1'b0);
    // Reset pulse at div=6 of a left slot, with a load pending
    guard = 0;
    while ((m_n % FRAME) != DIV + 6 && guard < 100) begin
      step(1'b0, 8'hB4, 1'b0);
      guard++;
    end
    step(1'b1, 8'hB4, 1'b0);
    repeat (45) step(1'b0, 8'hD2, 1'b0);

    // Randomized traffic
    v = 8'h00; b = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 5) == 0) v = 8'($urandom);
      if ($urandom_range(0, 40) == 0) b = ~b;
      r = ($urandom_range(0, 249) == 0);
      step(r, v, b);
    end

    // Drain the scoreboard, bounded
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
